// File: rtl/usart_rx_core.sv
// USART receive core: oversampled 8N1/8E1/8O1 deserialiser with a small
// first-word-fall-through FIFO toward the bus-side register block.
module usart_rx_core #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_W      = 16
) (
   input  logic             io_clk,
   input  logic             io_reset,
   input  logic             rx_pin,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             parity_en,
   input  logic             parity_odd,
   output logic [7:0]       rx_data,
   output logic             rx_perr,
   output logic             rx_ferr,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             overrun,
   input  logic             overrun_clr,
   output logic             busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e           state_q, state_d;
   logic             sync1_q, sync2_q, hist_q;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] half;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             perr_q, perr_d;
   logic             samp_a_q, samp_a_d, samp_b_q, samp_b_d;
   logic             at_a, at_b, at_res, at_wrap, maj, fall;
   logic             push, push_ferr;

   logic [9:0]       mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             empty, full, pop, do_push, overrun_q;
   logic [9:0]       head;

   assign fall    = hist_q & ~sync2_q;
   assign half    = div_q >> 1;
   assign at_a    = (cnt_q == half - DIV_W'(1));
   assign at_b    = (cnt_q == half);
   assign at_res  = (cnt_q == half + DIV_W'(1));
   assign at_wrap = (cnt_q == div_q - DIV_W'(1));
   assign maj     = (samp_a_q & samp_b_q) | (samp_a_q & sync2_q) | (samp_b_q & sync2_q);
   assign busy    = (state_q != StIdle);

   always_comb begin
      state_d   = state_q;
      cnt_d     = at_wrap ? '0 : cnt_q + DIV_W'(1);
      div_d     = div_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      perr_d    = perr_q;
      samp_a_d  = at_a ? sync2_q : samp_a_q;
      samp_b_d  = at_b ? sync2_q : samp_b_q;
      push      = 1'b0;
      push_ferr = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (fall) begin
               state_d = StStart;
               div_d   = baud_div;
               bit_d   = '0;
               perr_d  = 1'b0;
            end
         end
         StStart: begin
            if (at_res && maj) state_d = StIdle;
            else if (at_wrap)  state_d = StData;
         end
         StData: begin
            if (at_res) shift_d = {maj, shift_q[7:1]};
            if (at_wrap) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = parity_en ? StParity : StStop;
            end
         end
         StParity: begin
            if (at_res) perr_d = ((^shift_q) ^ maj) != parity_odd;
            if (at_wrap) state_d = StStop;
         end
         StStop: begin
            // Wrap fallback keeps an illegal tiny divisor from stalling here.
            if (at_res || at_wrap) begin
               push      = 1'b1;
               push_ferr = ~maj;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge io_clk) begin
      if (io_reset) begin
         state_q  <= StIdle;
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         hist_q   <= 1'b1;
         cnt_q    <= '0;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         perr_q   <= 1'b0;
         samp_a_q <= 1'b1;
         samp_b_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         sync1_q  <= rx_pin;
         sync2_q  <= sync1_q;
         hist_q   <= sync2_q;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         perr_q   <= perr_d;
         samp_a_q <= samp_a_d;
         samp_b_q <= samp_b_d;
      end
   end

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rx_valid = ~empty;
   assign pop     = rx_valid & rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | pop);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign rx_data = rx_valid ? head[7:0] : 8'h00;
   assign rx_perr = rx_valid & head[8];
   assign rx_ferr = rx_valid & head[9];
   assign overrun = overrun_q;

   always_ff @(posedge io_clk) begin
      if (io_reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         overrun_q <= (overrun_q & ~overrun_clr) | (push & full & ~pop);
      end
   end

   always_ff @(posedge io_clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {push_ferr, perr_q, shift_q};
   end

endmodule

// File: tb/tb_usart_rx_core.sv
// Directed bench for usart_rx_core: a vector table of single frames plus
// hand-written sequences for latency, FIFO, overrun, glitch and reset cases.
module tb_usart_rx_core;

   logic        io_clk = 1'b0;
   logic        io_reset;
   logic        rx_pin;
   logic [15:0] baud_div;
   logic        parity_en, parity_odd;
   logic [7:0]  rx_data;
   logic        rx_perr, rx_ferr, rx_valid;
   logic        rx_ready;
   logic        overrun;
   logic        overrun_clr;
   logic        busy;

   always #5 io_clk = ~io_clk;

   usart_rx_core #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
      .io_clk      (io_clk),
      .io_reset    (io_reset),
      .rx_pin      (rx_pin),
      .baud_div    (baud_div),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .rx_data     (rx_data),
      .rx_perr     (rx_perr),
      .rx_ferr     (rx_ferr),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .busy        (busy)
   );

   typedef struct {
      logic [15:0] div;
      logic        pen;
      logic        podd;
      logic        pbit;
      logic [7:0]  d;
      logic        stopv;
      logic [7:0]  e_data;
      logic        e_perr;
      logic        e_ferr;
   } vec_t;

   vec_t vecs [8];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int div);
      rx_pin = v;
      repeat (div) @(negedge io_clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int div, input logic pen,
                             input logic pbit, input logic stopv);
      drive_bit(1'b0, div);
      for (int i = 0; i < 8; i++) drive_bit(d[i], div);
      if (pen) drive_bit(pbit, div);
      drive_bit(stopv, div);
   endtask

   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (!rx_valid && n < max) begin
         @(negedge io_clk);
         n++;
      end
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      @(negedge io_clk);
      rx_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rx_valid"}, {31'd0, rx_valid}, 0);
      check({tag, " rx_data"},  {24'd0, rx_data},  0);
      check({tag, " rx_perr"},  {31'd0, rx_perr},  0);
      check({tag, " rx_ferr"},  {31'd0, rx_ferr},  0);
      check({tag, " overrun"},  {31'd0, overrun},  0);
      check({tag, " busy"},     {31'd0, busy},     0);
   endtask

   initial begin
      int n;
      logic [7:0] exp_b2b [3];
      vecs[0] = '{16'd16, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 8'h07, 1'b0, 1'b0};
      vecs[1] = '{16'd16, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 8'h07, 1'b1, 1'b0};
      vecs[2] = '{16'd16, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 8'h07, 1'b0, 1'b0};
      vecs[3] = '{16'd8,  1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 8'hC3, 1'b0, 1'b0};
      vecs[4] = '{16'd4,  1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{16'd4,  1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{16'd12, 1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 8'h81, 1'b0, 1'b0};
      vecs[7] = '{16'd5,  1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b1};
      exp_b2b = '{8'h55, 8'h00, 8'hFF};

      io_reset = 1'b1; rx_pin = 1'b1; baud_div = 16'd4; parity_en = 1'b0;
      parity_odd = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
      repeat (3) @(negedge io_clk);
      check_reset_outputs("por");
      io_reset = 1'b0;
      repeat (4) @(negedge io_clk);

      // 0xAA at 4 clocks per bit: latency and busy release
      send_frame(8'hAA, 4, 1'b0, 1'b0, 1'b1);
      check("aa busy during stop", {31'd0, busy}, 1);
      wait_valid(20, n);
      check("aa valid latency", n, 3);
      check("aa data", {24'd0, rx_data}, 32'hAA);
      check("aa perr", {31'd0, rx_perr}, 0);
      check("aa ferr", {31'd0, rx_ferr}, 0);
      check("aa busy after stop", {31'd0, busy}, 0);
      pop_one();
      check("aa empty after pop", {31'd0, rx_valid}, 0);
      repeat (8) @(negedge io_clk);

      for (int v = 0; v < 8; v++) begin
         baud_div = vecs[v].div; parity_en = vecs[v].pen; parity_odd = vecs[v].podd;
         @(negedge io_clk);
         send_frame(vecs[v].d, int'(vecs[v].div), vecs[v].pen, vecs[v].pbit, vecs[v].stopv);
         rx_pin = 1'b1;
         wait_valid(3 * int'(vecs[v].div) + 10, n);
         check($sformatf("vec%0d valid", v), {31'd0, rx_valid}, 1);
         check($sformatf("vec%0d data", v), {24'd0, rx_data}, {24'd0, vecs[v].e_data});
         check($sformatf("vec%0d perr", v), {31'd0, rx_perr}, {31'd0, vecs[v].e_perr});
         check($sformatf("vec%0d ferr", v), {31'd0, rx_ferr}, {31'd0, vecs[v].e_ferr});
         pop_one();
         check($sformatf("vec%0d empty", v), {31'd0, rx_valid}, 0);
         repeat (2 * int'(vecs[v].div)) @(negedge io_clk);
      end

      // back-to-back frames, no idle gap
      baud_div = 16'd16; parity_en = 1'b0; parity_odd = 1'b0;
      @(negedge io_clk);
      send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1);
      send_frame(8'h00, 16, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge io_clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b%0d valid", i), {31'd0, rx_valid}, 1);
         check($sformatf("b2b%0d data", i), {24'd0, rx_data}, {24'd0, exp_b2b[i]});
         pop_one();
      end
      check("b2b drained", {31'd0, rx_valid}, 0);

      // framing error, then line stuck low
      baud_div = 16'd8;
      @(negedge io_clk);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      repeat (150) @(negedge io_clk);
      check("ferr valid", {31'd0, rx_valid}, 1);
      check("ferr data", {24'd0, rx_data}, 32'h3C);
      check("ferr flag", {31'd0, rx_ferr}, 1);
      pop_one();
      check("stuck low no entry", {31'd0, rx_valid}, 0);
      check("stuck low idle", {31'd0, busy}, 0);
      rx_pin = 1'b1;
      repeat (16) @(negedge io_clk);
      send_frame(8'h42, 8, 1'b0, 1'b0, 1'b1);
      wait_valid(40, n);
      check("after ferr data", {24'd0, rx_data}, 32'h42);
      check("after ferr flag", {31'd0, rx_ferr}, 0);
      pop_one();

      // overrun with a 4-deep FIFO
      baud_div = 16'd16;
      @(negedge io_clk);
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 16, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge io_clk);
      check("overrun set", {31'd0, overrun}, 1);
      overrun_clr = 1'b1;
      @(negedge io_clk);
      overrun_clr = 1'b0;
      check("overrun cleared", {31'd0, overrun}, 0);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovr%0d data", i), {24'd0, rx_data}, i);
         pop_one();
      end
      check("ovr drained", {31'd0, rx_valid}, 0);

      // 2-clock low glitch is a false start
      rx_pin = 1'b0;
      repeat (2) @(negedge io_clk);
      rx_pin = 1'b1;
      repeat (2) @(negedge io_clk);
      check("glitch busy", {31'd0, busy}, 1);
      repeat (30) @(negedge io_clk);
      check("glitch idle", {31'd0, busy}, 0);
      check("glitch no entry", {31'd0, rx_valid}, 0);

      // reset in the middle of data bit 3 with a byte waiting in the FIFO
      send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge io_clk);
      check("pre-reset entry", {31'd0, rx_valid}, 1);
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b0, 8);
      io_reset = 1'b1; rx_pin = 1'b1;
      @(negedge io_clk);
      check_reset_outputs("midframe");
      io_reset = 1'b0;
      repeat (40) @(negedge io_clk);
      check("post-reset quiet", {31'd0, rx_valid}, 0);
      send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1);
      wait_valid(60, n);
      check("post-reset valid", {31'd0, rx_valid}, 1);
      check("post-reset data", {24'd0, rx_data}, 32'hA5);
      pop_one();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/usart_rx_core.md
Name: usart_rx_core

Overview:
- Receive half of the USART peripheral in the CyberPlus SoC.
- Consumes the serial line driven onto the USART1_RX pin (GPIOB[1]) and deserialises 8N1/8E1/8O1 frames.
- Pushes received bytes and their error flags into a small FIFO that the bus-side register block drains through a valid/ready handshake.
- Baud rate is set at runtime by a clocks-per-bit divisor, as in the USART BRR register.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >=2.
- DIV_W, 16, width of the baud divisor.

Ports:
- io_clk  input  1  system clock; all logic on the rising edge.
- io_reset  input  1  synchronous, active-high reset.
- rx_pin  input  1  asynchronous serial line, idle high.
- baud_div  input  DIV_W  clocks per bit; legal range >=4; sampled only in IDLE.
- parity_en  input  1  1 = a parity bit follows the data bits.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- rx_data  output  8  byte at the FIFO head.
- rx_perr  output  1  parity error flag of the head entry.
- rx_ferr  output  1  framing error flag of the head entry.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pops the head when rx_valid && rx_ready.
- overrun  output  1  sticky; a byte was dropped because the FIFO was full.
- overrun_clr  input  1  clears overrun.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: FSM=IDLE, bit counter=0, FIFO empty, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, overrun=0, busy=0, both synchroniser flops=1. A reset mid-frame discards the partial frame.
- Input sync: two-flop synchroniser, then one history flop. A falling edge is history=1 and sync=0. Detection latency is 3 cycles after the pin change.
- Timing: div is latched from baud_div on leaving IDLE; half = div>>1.
- In every non-IDLE state, cnt counts 0..div-1 and wraps to 0 at div-1, advancing the bit.
- Samples are taken at cnt = half-1, half and half+1. The bit value is the 2-of-3 majority, resolved at cnt==half+1.
- States:
  - IDLE: on falling edge -> START, cnt=0.
  - START: if the majority is 1 -> IDLE (false start, nothing written); else continue to DATA at wrap.
  - DATA: 8 bits, LSB first, shifted in at resolution. After bit 7 wraps -> PARITY if parity_en, else STOP.
  - PARITY: perr = (XOR of data ^ parity bit) != parity_odd, i.e. even parity requires the total count of 1s to be even. Wraps -> STOP.
  - STOP: ferr = (majority==0). At resolution (cnt==half+1), write {ferr, perr, data} to the FIFO and go directly to IDLE without waiting for wrap, so the next start edge is not missed. perr=0 when parity_en=0.
- A framing-error frame is still written. After a ferr, IDLE requires a genuine 1->0 edge, so a stuck-low line produces no further frames.
- FIFO: standard circular buffer, outputs come from the head entry (first-word fall-through).
  - Write and pop in the same cycle while full: the pop frees a slot and the write succeeds; no overrun.
  - Write while full and no pop: byte dropped, overrun<=1, FIFO unchanged.
  - overrun_clr and a new overrun in the same cycle: overrun stays 1.
  - Pop while empty is ignored.
- baud_div changes during a frame have no effect until the next IDLE. baud_div<4 is illegal; behaviour is undefined but must not hang (FSM returns to IDLE on reset).

Test Plan:
- baud_div=4, parity_en=0; drive 0xAA with 4-clock bits (start 0, LSB first, stop 1), rx_ready=0 -> rx_valid rises ~3+4*9+3 cycles after the start edge; rx_data=0xAA, rx_perr=0, rx_ferr=0; busy low after the stop sample.
- baud_div=16; send 0x55, 0x00, 0xFF back-to-back, no idle gap -> three FIFO entries in order; popping with rx_ready=1 yields 0x55, 0x00, 0xFF, then rx_valid=0.
- baud_div=16, parity_en=1, parity_odd=0; send 0x07 with parity bit 1 -> perr=0. Resend with parity bit 0 -> perr=1. Set parity_odd=1 with parity bit 0 -> perr=0.
- baud_div=8; send 0x3C with stop bit driven 0, then hold the line low -> one entry rx_data=0x3C, rx_ferr=1; no further entries until the line returns high and a new start edge occurs.
- FIFO_DEPTH=4, rx_ready=0; send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04, overrun=1. overrun_clr pulse -> overrun=0. A 2-clock low glitch at baud_div=16 -> false start, no entry written, busy returns to 0.
- Assert io_reset during DATA bit 3 of a frame -> all outputs at reset values next cycle; a following clean 0xA5 frame is received correctly.
